// File: rtl/rl_queue_lvl.sv
// rl_queue_lvl -- fall-through queue with fill level, thresholds and sticky errors.
//
// Entry 0 is the head and drives q_o directly; a read shifts every entry one
// place toward entry 0 and zeroes the top. A write lands in the first free
// slot (or the slot just vacated by a simultaneous read), so a full queue can
// accept a write in the same cycle as a read.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   clr_i          synchronous clear (same effect as reset), beats ena_i
//   ena_i          clock enable; low holds all state except error clearing
//   we_i, d_i      write enable and data
//   re_i           read enable; pops entry 0
//   err_clr_i      synchronous clear of ovf_o/unf_o, independent of ena_i
//   q_o            head entry, 0 when empty
//   level_o        number of valid entries 0..DEPTH
//   empty_o/full_o level==0 / level==DEPTH
//   almost_empty_o level <= AEMPTY_LVL
//   almost_full_o  level >= AFULL_LVL
//   ovf_o          sticky: write dropped because full
//   unf_o          sticky: read issued while empty
module rl_queue_lvl #(
  parameter int DEPTH      = 4,
  parameter int DBITS      = 32,
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       ena_i,
  input  logic                       we_i,
  input  logic [DBITS-1:0]           d_i,
  input  logic                       re_i,
  input  logic                       err_clr_i,
  output logic [DBITS-1:0]           q_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       almost_empty_o,
  output logic                       almost_full_o,
  output logic                       ovf_o,
  output logic                       unf_o
);

  localparam int LW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || DBITS < 1 || AEMPTY_LVL < 0 ||
      AEMPTY_LVL >= AFULL_LVL || AFULL_LVL > DEPTH) begin : g_bad_param
    $fatal(1, "rl_queue_lvl: illegal parameter combination");
  end

  logic [DEPTH-1:0][DBITS-1:0] entry_reg;
  logic [DEPTH-1:0][DBITS-1:0] entry_next;
  logic [LW-1:0]               level_reg;
  logic [LW-1:0]               level_next;
  logic                        ovf_reg;
  logic                        ovf_next;
  logic                        unf_reg;
  logic                        unf_next;

  logic          is_empty;
  logic          is_full;
  logic          re;
  logic          we;
  logic [LW-1:0] wr_idx;

  assign is_empty = (level_reg == '0);
  assign is_full  = (level_reg == LW'(DEPTH));

  // Effective handshakes: a read needs data; a write needs room, where a
  // concurrent read counts as making room.
  assign re = ena_i & re_i & ~is_empty;
  assign we = ena_i & we_i & (~is_full | re);

  // With a concurrent read the tail has already moved down one slot.
  assign wr_idx = re ? (level_reg - LW'(1)) : level_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DBITS-1:0] shifted;
    if (gi < DEPTH - 1) begin : g_mid
      assign shifted = entry_reg[gi+1];
    end else begin : g_top
      assign shifted = '0;
    end
    assign entry_next[gi] = (we && wr_idx == LW'(gi)) ? d_i
                          : (re ? shifted : entry_reg[gi]);
  end

  always_comb begin
    level_next = level_reg;
    case ({we, re})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // A new error in the same cycle as err_clr_i wins.
  assign ovf_next = (ovf_reg & ~err_clr_i) | (ena_i & we_i & is_full & ~re);
  assign unf_next = (unf_reg & ~err_clr_i) | (ena_i & re_i & is_empty);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_reg <= '0;
      level_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else if (clr_i) begin
      entry_reg <= '0;
      level_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      entry_reg <= entry_next;
      level_reg <= level_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign q_o            = entry_reg[0];
  assign level_o        = level_reg;
  assign empty_o        = is_empty;
  assign full_o         = is_full;
  assign almost_empty_o = (level_reg <= LW'(AEMPTY_LVL));
  assign almost_full_o  = (level_reg >= LW'(AFULL_LVL));
  assign ovf_o          = ovf_reg;
  assign unf_o          = unf_reg;

`ifndef SYNTHESIS
  a_level_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    level_reg <= LW'(DEPTH));
  a_not_empty_and_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(is_empty && is_full));
  a_empty_head_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
    is_empty |-> (entry_reg[0] == '0));
`endif

endmodule
